// File: rtl/lcd_write_scheduler_if.sv
// Requester-side bundle for the LCD write scheduler: per-requester byte requests plus grant/busy status.
interface lcd_write_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rs;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              busy;

  modport master (output req, output req_rs, output req_data, input ack, input busy);
  modport slave  (input req, input req_rs, input req_data, output ack, output busy);
endinterface

// File: rtl/lcd_write_scheduler.sv
// Round-robin arbiter and nibble sequencer sharing the 4-bit HD44780 character LCD between NREQ requesters.
module lcd_write_scheduler #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned E_CYC     = 12,
  parameter int unsigned GAP_CYC   = 50,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLR_CYC   = 82000
) (
  input  logic                   clk,
  input  logic                   rst,
  lcd_write_scheduler_if.slave   bus,
  output logic                   sf_ce0,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_e,
  output logic [3:0]             lcd_d
);

  localparam int unsigned CNT_W = $clog2(CLR_CYC + 1);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP_H, PULSE_H, GAP, SETUP_L, PULSE_L, EXEC
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] rr_ptr;
  logic [7:0]       data_q;
  logic             rs_q;

  logic [NREQ-1:0]  rot_c;
  logic             gnt_vld_c;
  logic [PTR_W-1:0] gnt_idx_c;
  logic [PTR_W-1:0] nxt_ptr_c;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] inc_c;
  logic [7:0]       gnt_data_c;
  logic             gnt_rs_c;
  logic             is_clr_c;

  // Rotate requests so rr_ptr sits at bit 0; the first set bit is the next grant.
  always_comb begin
    rot_c     = NREQ'({bus.req, bus.req} >> rr_ptr);
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    sum_c     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!gnt_vld_c && rot_c[k]) begin
        gnt_vld_c = 1'b1;
        sum_c     = SUM_W'(rr_ptr) + SUM_W'(k);
        if (sum_c >= SUM_W'(NREQ)) sum_c = sum_c - SUM_W'(NREQ);
        gnt_idx_c = PTR_W'(sum_c);
      end
    end
    inc_c      = SUM_W'(gnt_idx_c) + SUM_W'(1);
    nxt_ptr_c  = (inc_c >= SUM_W'(NREQ)) ? '0 : PTR_W'(inc_c);
    gnt_data_c = 8'(bus.req_data >> {gnt_idx_c, 3'b000});
    gnt_rs_c   = 1'(bus.req_rs >> gnt_idx_c);
  end

  // Clear and home commands need the long execution wait.
  assign is_clr_c = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      bus.ack  <= '0;
      bus.busy <= 1'b0;
      sf_ce0   <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_d    <= '0;
    end else begin
      bus.ack <= '0;
      sf_ce0  <= 1'b1;
      lcd_rw  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld_c) begin
            bus.ack  <= NREQ'(1) << gnt_idx_c;
            bus.busy <= 1'b1;
            data_q   <= gnt_data_c;
            rs_q     <= gnt_rs_c;
            rr_ptr   <= nxt_ptr_c;
            lcd_d    <= gnt_data_c[7:4];
            lcd_rs   <= gnt_rs_c;
            lcd_e    <= 1'b0;
            cnt      <= SETUP_LD;
            state    <= SETUP_H;
          end
        end
        SETUP_H: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= E_LD;
            state <= PULSE_H;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE_H: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            cnt   <= GAP_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            lcd_d <= data_q[3:0];
            cnt   <= SETUP_LD;
            state <= SETUP_L;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETUP_L: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= E_LD;
            state <= PULSE_L;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE_L: begin
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            lcd_d <= '0;
            cnt   <= is_clr_c ? CLR_LD : EXEC_LD;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          lcd_e    <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomized bench for lcd_write_scheduler: arbitration order and per-write LCD bus timing against a reference model.
module tb_lcd_write_scheduler;

  localparam int NREQ      = 4;
  localparam int SETUP_CYC = 2;
  localparam int E_CYC     = 12;
  localparam int GAP_CYC   = 50;
  localparam int EXEC_CYC  = 300;
  localparam int CLR_CYC   = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic       sf_ce0, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;

  always #5 clk = ~clk;

  lcd_write_scheduler_if #(.NREQ(NREQ)) bus ();

  lcd_write_scheduler #(
    .NREQ(NREQ), .SETUP_CYC(SETUP_CYC), .E_CYC(E_CYC), .GAP_CYC(GAP_CYC),
    .EXEC_CYC(EXEC_CYC), .CLR_CYC(CLR_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sf_ce0(sf_ce0), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  int vectors = 0;
  int miscompares = 0;
  int rwce_bad = 0;
  int t_wait;

  // Requester-side model state
  logic [NREQ-1:0] req_m;
  logic            rs_m   [NREQ];
  logic [7:0]      data_m [NREQ];
  int              rr_m;
  logic [NREQ-1:0] nr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (lcd_rw !== 1'b0 || sf_ce0 !== 1'b1) rwce_bad++;

  function automatic int exp_grant(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? CLR_CYC : EXEC_CYC;
  endfunction

  task automatic drive();
    bus.req = req_m;
    for (int k = 0; k < NREQ; k++) begin
      bus.req_rs[k]        = rs_m[k];
      bus.req_data[8*k+:8] = data_m[k];
    end
  endtask

  task automatic new_data(input int k);
    if ($urandom_range(0, 5) == 0) begin
      rs_m[k]   = 1'b0;
      data_m[k] = 8'($urandom_range(1, 3));
    end else begin
      rs_m[k]   = 1'($urandom);
      data_m[k] = 8'($urandom);
    end
  endtask

  task automatic set_req(input int k, input logic rs, input logic [7:0] d);
    req_m[k] = 1'b1; rs_m[k] = rs; data_m[k] = d;
  endtask

  // Called at a falling edge with the DUT idle and requests already driven; serves one write.
  task automatic serve(input bit drop, input logic [NREQ-1:0] add, input logic [NREQ-1:0] wd);
    int g, t, r1, f1, r2, f2, xl, ack_extra;
    logic [7:0] d;
    logic rs, s1, s2, pe;
    logic [3:0] n1, n2;
    g = exp_grant(req_m, rr_m);
    @(negedge clk);
    if (g < 0) begin
      check("no_req_ack", 32'(bus.ack), 32'd0);
      check("no_req_busy", 32'(bus.busy), 32'd0);
      return;
    end
    check("grant", 32'(bus.ack), 32'd1 << g);
    d = data_m[g]; rs = rs_m[g]; xl = exec_len(rs, d);
    rr_m = (g + 1) % NREQ;
    if (drop) begin req_m[g] = 1'b0; new_data(g); drive(); end
    r1 = -1; f1 = -1; r2 = -1; f2 = -1; pe = 1'b0; ack_extra = 0; t = 0;
    n1 = '0; n2 = '0; s1 = 1'b0; s2 = 1'b0;
    while (bus.busy === 1'b1 && t < CLR_CYC + 200) begin
      if (t > 0 && bus.ack !== '0) ack_extra++;
      if (lcd_e && !pe) begin
        if (r1 < 0) begin r1 = t; n1 = lcd_d; s1 = lcd_rs; end
        else begin r2 = t; n2 = lcd_d; s2 = lcd_rs; end
      end
      if (!lcd_e && pe) begin
        if (f1 < 0) f1 = t; else f2 = t;
      end
      pe = lcd_e;
      if (t == 5) begin
        for (int k = 0; k < NREQ; k++) if (add[k] && !req_m[k]) new_data(k);
        req_m = req_m | add; drive();
      end
      if (t == 20) begin req_m = req_m & ~wd; drive(); end
      @(negedge clk); t++;
    end
    check("e_rise_hi", 32'(r1), 32'(SETUP_CYC));
    check("e_width_hi", 32'(f1 - r1), 32'(E_CYC));
    check("gap_to_lo", 32'(r2 - f1), 32'(GAP_CYC + SETUP_CYC));
    check("e_width_lo", 32'(f2 - r2), 32'(E_CYC));
    check("exec_len", 32'(t - f2), 32'(xl));
    check("busy_len", 32'(t), 32'(2*SETUP_CYC + 2*E_CYC + GAP_CYC + xl));
    check("nib_hi", 32'(n1), 32'(d[7:4]));
    check("nib_lo", 32'(n2), 32'(d[3:0]));
    check("rs_hi", 32'(s1), 32'(rs));
    check("rs_lo", 32'(s2), 32'(rs));
    check("ack_pulse", 32'(ack_extra), 32'd0);
    check("d_after", 32'(lcd_d), 32'd0);
  endtask

  initial begin
    req_m = '0; rr_m = 0;
    for (int k = 0; k < NREQ; k++) begin rs_m[k] = 1'b0; data_m[k] = 8'h00; end
    drive();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_d", 32'(lcd_d), 32'd0);
    check("rst_ce0", 32'(sf_ce0), 32'd1);
    rst = 1'b0;

    // Single data write, then a clear and a normal command
    set_req(0, 1'b1, 8'h48); drive(); serve(1'b1, '0, '0);
    set_req(1, 1'b0, 8'h01); drive(); serve(1'b1, '0, '0);
    set_req(1, 1'b0, 8'h0C); drive(); serve(1'b1, '0, '0);

    // All requesters held: round-robin order
    for (int k = 0; k < NREQ; k++) set_req(k, 1'b1, 8'(8'h30 + k));
    drive();
    repeat (5) serve(1'b0, '0, '0);
    req_m = '0; drive();

    // Wrap-around search
    set_req(0, 1'b1, 8'h55); set_req(3, 1'b1, 8'hA3); drive();
    serve(1'b1, '0, '0); serve(1'b1, '0, '0);
    set_req(1, 1'b1, 8'h7E); drive(); serve(1'b1, '0, '0);

    // Request appears then withdraws while another write is busy
    set_req(0, 1'b1, 8'hC5); drive();
    serve(1'b1, 4'b0100, 4'b0100);
    serve(1'b1, '0, '0);

    // Reset during the high-nibble E pulse
    set_req(0, 1'b1, 8'h41); drive();
    serve_reset();

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      nr = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) if (nr[k] && !req_m[k]) new_data(k);
      if ($urandom_range(0, 4) == 0) req_m = nr; else req_m = req_m | nr;
      drive();
      serve($urandom_range(0, 3) != 0, NREQ'($urandom), NREQ'($urandom));
    end

    check("rw_ce_static", 32'(rwce_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic serve_reset();
    @(negedge clk);
    check("pre_rst_grant", 32'(bus.ack), 32'd1 << exp_grant(req_m, rr_m));
    req_m = '0; drive();
    t_wait = 0;
    while (lcd_e !== 1'b1 && t_wait < 50) begin @(negedge clk); t_wait++; end
    check("pulse_h_seen", 32'(lcd_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_e", 32'(lcd_e), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_d", 32'(lcd_d), 32'd0);
    check("arst_rs", 32'(lcd_rs), 32'd0);
    check("arst_ce0", 32'(sf_ce0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    rr_m = 0;
    set_req(0, 1'b1, 8'h6A); set_req(3, 1'b0, 8'h80); drive();
    serve(1'b1, '0, '0);
    serve(1'b1, '0, '0);
  endtask

endmodule
